// File: rtl/mandel_frame_scheduler.sv
// Raster-order pixel dispatcher for an array of pointGenerator engines; collects
// iteration counts and writes them to the frame buffer at y*H_RES+x.
module mandel_frame_scheduler #(
  parameter int unsigned NUM_ENG = 4,
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned HBI     = 32,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   frame_start,
  output logic                   busy,
  output logic                   frame_done,
  output logic [NUM_ENG-1:0]     eng_start,
  output logic [12*NUM_ENG-1:0]  eng_x,
  output logic [12*NUM_ENG-1:0]  eng_y,
  input  logic [NUM_ENG-1:0]     eng_done,
  input  logic [HBI*NUM_ENG-1:0] eng_iter,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [HBI-1:0]         wr_data,
  input  logic                   wr_ready
);

  localparam logic [11:0] X_LAST = 12'(H_RES - 1);
  localparam logic [11:0] Y_LAST = 12'(V_RES - 1);
  localparam int unsigned SW     = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DRAIN} top_e;
  typedef enum logic [2:0] {S_WAIT, S_FREE, S_ISSUE, S_GUARD, S_RUN, S_DONE} slot_e;

  top_e                  top_q, top_d;
  slot_e                 slot_q [NUM_ENG];
  slot_e                 slot_d [NUM_ENG];
  logic [ADDR_W-1:0]     saddr_q [NUM_ENG];
  logic [ADDR_W-1:0]     saddr_d [NUM_ENG];
  logic [11:0]           x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [12*NUM_ENG-1:0] ex_q, ex_d, ey_q, ey_d;
  logic                  busy_q, busy_d, fdone_q, fdone_d;
  logic                  wen_q, wen_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [HBI-1:0]        wdata_q, wdata_d;
  logic [SW-1:0]         wslot_q, wslot_d;

  logic [NUM_ENG-1:0]    disp_sel, load_sel, elig;
  logic                  disp_found, hi_found, lo_found, load_ok, wr_acc, all_free;
  int unsigned           hi_idx, lo_idx, pick;

  assign wr_acc = wen_q && wr_ready;

  // Lowest FREE slot wins dispatch; DONE slots are loaded round-robin after the
  // last loaded slot, skipping the one still sitting in the output register.
  always_comb begin
    disp_sel   = '0;
    disp_found = 1'b0;
    elig       = '0;
    hi_found   = 1'b0;
    lo_found   = 1'b0;
    hi_idx     = 0;
    lo_idx     = 0;
    all_free   = 1'b1;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      if (!disp_found && top_q == T_RUN && slot_q[i] == S_FREE) begin
        disp_sel[i] = 1'b1;
        disp_found  = 1'b1;
      end
      elig[i] = (slot_q[i] == S_DONE) && !(wen_q && 32'(wslot_q) == i);
      if (slot_q[i] != S_FREE) all_free = 1'b0;
    end
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      if (elig[i] && !hi_found && i > 32'(wslot_q)) begin
        hi_found = 1'b1;
        hi_idx   = i;
      end
      if (elig[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = i;
      end
    end
    pick     = hi_found ? hi_idx : lo_idx;
    load_ok  = (!wen_q || wr_ready) && (|elig);
    load_sel = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++)
      load_sel[i] = load_ok && (i == pick);
  end

  always_comb begin
    top_d   = top_q;
    busy_d  = busy_q;
    fdone_d = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    slot_d  = slot_q;
    saddr_d = saddr_q;
    wen_d   = wen_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wslot_d = wslot_q;

    case (top_q)
      T_IDLE: if (frame_start) begin
        top_d  = T_RUN;
        busy_d = 1'b1;
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
      end
      T_DRAIN: if (all_free && !wen_q) begin
        top_d   = T_IDLE;
        busy_d  = 1'b0;
        fdone_d = 1'b1;
      end
      default: ;
    endcase

    if (|disp_sel) begin
      addr_d = addr_q + ADDR_W'(1);
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 12'd1;
        if (y_q == Y_LAST) top_d = T_DRAIN;
      end else begin
        x_d = x_q + 12'd1;
      end
    end

    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      case (slot_q[i])
        S_WAIT:  if (eng_done[i]) slot_d[i] = S_FREE;
        S_FREE:  if (disp_sel[i]) begin
          slot_d[i]          = S_ISSUE;
          saddr_d[i]         = addr_q;
          ex_d[12*i +: 12]   = x_q;
          ey_d[12*i +: 12]   = y_q;
        end
        S_ISSUE: slot_d[i] = S_GUARD;
        S_GUARD: slot_d[i] = S_RUN;
        S_RUN:   if (eng_done[i]) slot_d[i] = S_DONE;
        S_DONE:  if (wr_acc && 32'(wslot_q) == i) slot_d[i] = S_FREE;
        default: slot_d[i] = S_WAIT;
      endcase
    end

    if (!wen_q || wr_ready) begin
      wen_d = load_ok;
      for (int unsigned i = 0; i < NUM_ENG; i++) begin
        if (load_sel[i]) begin
          waddr_d = saddr_q[i];
          wdata_d = eng_iter[HBI*i +: HBI];
          wslot_d = SW'(i);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      top_q   <= T_IDLE;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wslot_q <= '0;
      for (int unsigned i = 0; i < NUM_ENG; i++) begin
        slot_q[i]  <= S_WAIT;
        saddr_q[i] <= '0;
      end
    end else begin
      top_q   <= top_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wslot_q <= wslot_d;
      slot_q  <= slot_d;
      saddr_q <= saddr_d;
    end
  end

  always_comb begin
    eng_start = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++)
      eng_start[i] = (slot_q[i] == S_ISSUE);
  end

  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign eng_x      = ex_q;
  assign eng_y      = ey_q;
  assign wr_en      = wen_q;
  assign wr_addr    = waddr_q;
  assign wr_data    = wdata_q;

endmodule

// File: tb/tb_mandel_frame_scheduler.sv
// Directed bench for mandel_frame_scheduler: behavioural engines (iter = x^y) and
// an address scoreboard, with a second 1x1 single-engine instance.
module tb_mandel_frame_scheduler;

  localparam int unsigned NE = 4, HR = 8, VR = 4, HB = 32, AW = 8, NPIX = 32;

  logic clk = 1'b0, rst_n = 1'b0, fs = 1'b0, wr_ready = 1'b1, fs1 = 1'b0;
  logic busy, fdone, wr_en;
  logic [NE-1:0]    eng_start;
  logic [12*NE-1:0] eng_x, eng_y;
  logic [NE-1:0]    eng_done = '1;
  logic [HB*NE-1:0] eng_iter = '0;
  logic [AW-1:0]    wr_addr;
  logic [HB-1:0]    wr_data;

  logic        busy1, fdone1, wen1;
  logic [0:0]  es1;
  logic [11:0] ex1, ey1;
  logic [0:0]  ed1 = 1'b1;
  logic [31:0] ei1 = '0;
  logic [3:0]  wa1;
  logic [31:0] wd1;

  int n_assert = 0, n_fail = 0;
  int lat_mode = 0;
  int cnt [NE];
  int cnt1 = 0;
  int wcount [NPIX];
  logic [HB-1:0] wdata_sb [NPIX];
  int n_writes = 0, bad_wr = 0, stab_err = 0, n_starts = 0;
  logic prev_hold = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [HB-1:0] p_data = '0;

  mandel_frame_scheduler #(.NUM_ENG(NE), .H_RES(HR), .V_RES(VR), .HBI(HB), .ADDR_W(AW)) dut (
    .CLK(clk), .RST_N(rst_n), .frame_start(fs), .busy(busy), .frame_done(fdone),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_done(eng_done),
    .eng_iter(eng_iter), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready));

  mandel_frame_scheduler #(.NUM_ENG(1), .H_RES(1), .V_RES(1), .HBI(32), .ADDR_W(4)) dut1 (
    .CLK(clk), .RST_N(rst_n), .frame_start(fs1), .busy(busy1), .frame_done(fdone1),
    .eng_start(es1), .eng_x(ex1), .eng_y(ey1), .eng_done(ed1), .eng_iter(ei1),
    .wr_en(wen1), .wr_addr(wa1), .wr_data(wd1), .wr_ready(1'b1));

  always #5 clk = ~clk;

  // Engines keep stale done high for one cycle after start, then compute.
  always @(posedge clk) begin
    for (int i = 0; i < NE; i++) begin
      if (eng_start[i]) begin
        cnt[i] <= (lat_mode == 0) ? 5 : int'($urandom_range(40, 2));
        eng_iter[HB*i +: HB] <= {20'b0, eng_x[12*i +: 12] ^ eng_y[12*i +: 12]};
      end else if (cnt[i] > 0) begin
        cnt[i] <= cnt[i] - 1;
        eng_done[i] <= (cnt[i] == 1);
      end
    end
    if (es1[0]) begin
      cnt1 <= 3;
      ei1  <= {20'b0, ex1 ^ ey1};
    end else if (cnt1 > 0) begin
      cnt1   <= cnt1 - 1;
      ed1[0] <= (cnt1 == 1);
    end
  end

  always @(negedge clk) begin
    if (wr_en && wr_ready) begin
      n_writes++;
      if (int'(wr_addr) < NPIX) begin
        wcount[wr_addr]++;
        wdata_sb[wr_addr] = wr_data;
      end else bad_wr++;
    end
    if (prev_hold && (wr_en !== 1'b1 || wr_addr !== p_addr || wr_data !== p_data)) stab_err++;
    prev_hold = wr_en && !wr_ready;
    p_addr    = wr_addr;
    p_data    = wr_data;
    if (eng_start != '0) n_starts++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " frame_done"}, 64'(fdone), 64'd0);
    check({tag, " eng_start"}, 64'(eng_start), 64'd0);
    check({tag, " eng_x"}, 64'(eng_x), 64'd0);
    check({tag, " eng_y"}, 64'(eng_y), 64'd0);
    check({tag, " wr_en"}, 64'(wr_en), 64'd0);
    check({tag, " wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, " wr_data"}, 64'(wr_data), 64'd0);
  endtask

  task automatic run_frame(input string tag, input bit glitch, input bit stall);
    int base [NPIX];
    int bb, sb, fd, extra, busy_low, c, st0, w0;
    for (int a = 0; a < NPIX; a++) base[a] = wcount[a];
    bb = bad_wr; sb = stab_err; fd = 0; extra = 0; busy_low = 0; c = 0; st0 = 0; w0 = 0;
    fs = 1'b1;
    tick();
    fs = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    while (c < 3000 && fd == 0) begin
      if (fdone === 1'b1) fd++;
      else begin
        if (busy !== 1'b1) busy_low++;
        if (glitch && c == 10) fs = 1'b1;
        if (glitch && c == 11) fs = 1'b0;
        if (stall && c == 15) wr_ready = 1'b0;
        if (stall && c == 35) begin st0 = n_starts; w0 = n_writes; end
        if (stall && c == 65) begin
          check({tag, " starts while stalled"}, 64'(n_starts - st0), 64'd0);
          check({tag, " writes while stalled"}, 64'(n_writes - w0), 64'd0);
          check({tag, " wr_en held"}, 64'(wr_en), 64'd1);
          wr_ready = 1'b1;
        end
        tick();
        c++;
      end
    end
    check({tag, " frame_done seen"}, 64'(fd), 64'd1);
    check({tag, " busy gaps"}, 64'(busy_low), 64'd0);
    tick();
    check({tag, " frame_done width"}, 64'(fdone), 64'd0);
    check({tag, " busy after done"}, 64'(busy), 64'd0);
    for (int k = 0; k < 20; k++) begin
      if (fdone === 1'b1) extra++;
      tick();
    end
    check({tag, " extra frame_done"}, 64'(extra), 64'd0);
    for (int a = 0; a < NPIX; a++) begin
      check($sformatf("%s addr%0d count", tag, a), 64'(wcount[a] - base[a]), 64'd1);
      check($sformatf("%s addr%0d data", tag, a), 64'(wdata_sb[a]), 64'((a % HR) ^ (a / HR)));
    end
    check({tag, " out-of-range writes"}, 64'(bad_wr - bb), 64'd0);
    check({tag, " hold stability"}, 64'(stab_err - sb), 64'd0);
  endtask

  initial begin
    int w0, starts, writes, cw, cf;
    for (int a = 0; a < NPIX; a++) wcount[a] = 0;
    for (int i = 0; i < NE; i++) cnt[i] = 0;
    repeat (3) tick();
    check_zero_outputs("reset");
    check("reset dut1 busy", 64'(busy1), 64'd0);
    check("reset dut1 eng_start", 64'(es1), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    lat_mode = 0;
    run_frame("t1 fixed", 1'b0, 1'b0);
    lat_mode = 1;
    run_frame("t2 random", 1'b0, 1'b0);
    lat_mode = 0;
    run_frame("t3 stall", 1'b0, 1'b1);

    lat_mode = 1;
    fs = 1'b1;
    tick();
    fs = 1'b0;
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    check_zero_outputs("t4 midreset");
    rst_n = 1'b1;
    w0 = n_writes;
    repeat (60) tick();
    check("t4 stale writes", 64'(n_writes - w0), 64'd0);
    check("t4 idle busy", 64'(busy), 64'd0);
    run_frame("t4 restart", 1'b0, 1'b0);

    lat_mode = 0;
    run_frame("t5 glitch start", 1'b1, 1'b0);

    starts = 0; writes = 0; cw = -1; cf = -1;
    fs1 = 1'b1;
    tick();
    fs1 = 1'b0;
    for (int c = 0; c < 200 && cf < 0; c++) begin
      if (es1[0] === 1'b1) begin
        starts++;
        check("t6 eng_x", 64'(ex1), 64'd0);
        check("t6 eng_y", 64'(ey1), 64'd0);
      end
      if (wen1 === 1'b1) begin
        writes++;
        cw = c;
        check("t6 wr_addr", 64'(wa1), 64'd0);
        check("t6 wr_data", 64'(wd1), 64'd0);
      end
      if (fdone1 === 1'b1) cf = c;
      if (cf < 0) tick();
    end
    check("t6 starts", 64'(starts), 64'd1);
    check("t6 writes", 64'(writes), 64'd1);
    check("t6 frame_done seen", 64'(cf >= 0), 64'd1);
    check("t6 frame_done timing", 64'(cf - cw), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
